mem_responder: RTL

//   Memory-side responder for the multicycle CPU's memory strobes.
//   - Services single-word read/write requests from the control unit (memRead/memWrite) and datapath (address, store data).
//   - Responds after a programmable wait, with a one-cycle ready pulse and an error flag.
//   - A side-band load port preloads program/data words before the CPU runs.

---
 rtl/mem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the multicycle CPU's memory strobes.
//            Latches one single-word read/write request per strobe level,
//            waits a fixed number of cycles, performs the access, and
//            answers with a one-cycle ready pulse qualified by an error flag.
//            A side-band load port preloads words while the responder is idle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       synchronous, active-high
//   mem_read_i   in   1       read request level
//   mem_write_i  in   1       write request level
//   mem_addr_i   in   ADDR_W  word address of request
//   mem_wdata_i  in   DATA_W  store data
//   load_en_i    in   1       preload strobe (honoured in IDLE only)
//   load_addr_i  in   ADDR_W  preload address
//   load_data_i  in   DATA_W  preload data
//   mem_rdata_o  out  DATA_W  read data, held until the next successful read
//   mem_ready_o  out  1       one-cycle completion pulse
//   mem_err_o    out  1       qualifies mem_ready_o: request rejected
//   busy_o       out  1       high while an access is in flight (WAIT/DONE/HOLD)
// ============================================================================
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              mem_err_o,
  output logic              busy_o
);

  // Index width of the implemented array; addresses are range-checked
  // against DEPTH before being truncated to this width.
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                op_rd_q;
  logic                req_err_q;
  logic [IDX_W-1:0]    addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Request classification, evaluated at latch time only.
  logic w_req_in_range;
  logic w_load_in_range;
  logic w_req_err;

  assign w_req_in_range  = ({1'b0, mem_addr_i}  < DEPTH_EXT);
  assign w_load_in_range = ({1'b0, load_addr_i} < DEPTH_EXT);
  assign w_req_err       = (mem_read_i & mem_write_i) | ~w_req_in_range;

  // Single array write port shared by preload (IDLE) and CPU stores (end of
  // WAIT). Reset suppresses both, so a store dropped by reset never lands.
  logic              mem_we_d;
  logic [IDX_W-1:0]  mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = addr_q;
    mem_wdata_d = wdata_q;
    if (!reset) begin
      if (state_q == S_IDLE && load_en_i && w_load_in_range) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = load_addr_i[IDX_W-1:0];
        mem_wdata_d = load_data_i;
      end else if (state_q == S_WAIT && cnt_q == 4'd0 && !op_rd_q && !req_err_q) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = addr_q;
        mem_wdata_d = wdata_q;
      end
    end
  end

  // Array storage has no reset: contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Control FSM with registered outputs. mem_ready/mem_err are raised on the
  // edge that enters DONE, so they are high exactly while the FSM is in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_rd_q   <= 1'b0;
      req_err_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A preload owns the cycle; a coincident request is ignored.
          if (!load_en_i && (mem_read_i || mem_write_i)) begin
            op_rd_q   <= mem_read_i;
            req_err_q <= w_req_err;
            addr_q    <= mem_addr_i[IDX_W-1:0];
            wdata_q   <= mem_wdata_i;
            cnt_q     <= WAIT_INIT;
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (op_rd_q && !req_err_q) begin
              rdata_q <= mem_q[addr_q];
            end
            ready_q <= 1'b1;
            err_q   <= req_err_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // One request per strobe level: wait for the strobe to drop.
          if (!mem_read_i && !mem_write_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
